// File: rtl/arm_core_defs.sv
`default_nettype none
// ============================================================================
//  Module      : arm_core_defs (package)
//  Description : Shared Thumb / Thumb-2 encoding constants and helpers for the
//                instruction-fetch front end.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_core_defs;

  localparam int INST_W = 32;
  localparam int HW_W   = 16;

  // Leading five bits of a halfword that open a 32-bit Thumb-2 encoding
  localparam logic [4:0] THUMB32_PFX_A = 5'b11101;
  localparam logic [4:0] THUMB32_PFX_B = 5'b11110;
  localparam logic [4:0] THUMB32_PFX_C = 5'b11111;

  // High byte of the IT instruction (low nibble is the mask, non-zero)
  localparam logic [7:0] IT_OPC = 8'hbf;

  // True when the halfword is the first half of a 32-bit instruction
  function automatic logic is_thumb32(input logic [HW_W-1:0] hw);
    return (hw[15:11] == THUMB32_PFX_A) ||
           (hw[15:11] == THUMB32_PFX_B) ||
           (hw[15:11] == THUMB32_PFX_C);
  endfunction

  // True when the halfword is an IT instruction (mask == 0 is a hint, not IT)
  function automatic logic is_it_inst(input logic [HW_W-1:0] hw);
    return (hw[15:8] == IT_OPC) && (hw[3:0] != 4'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_hw_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : arm_hw_fifo
//  Description : Halfword circular buffer with one write port and a dual-head
//                read (H0 = oldest, H1 = next). Pops one or two entries.
//  Revision    : 1.0  initial release
// ============================================================================
module arm_hw_fifo
  import arm_core_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [HW_W-1:0]  i_wr_data,
  input  logic             i_pop_one,
  input  logic             i_pop_two,
  output logic [HW_W-1:0]  o_h0,
  output logic [HW_W-1:0]  o_h1,
  output logic [PTR_W:0]   o_count
);

  logic [HW_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic [PTR_W:0]   w_pop_n;
  logic [PTR_W-1:0] w_rd_ptr_p1;

  // A flush wins over a same-cycle write
  assign w_push      = i_push && !i_flush;
  assign w_pop_n     = i_pop_two ? (PTR_W+1)'(2) :
                       i_pop_one ? (PTR_W+1)'(1) : '0;
  // DEPTH is a power of two, so pointer arithmetic wraps for free
  assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);

  assign o_h0    = r_mem[r_rd_ptr];
  assign o_h1    = r_mem[w_rd_ptr_p1];
  assign o_count = r_count;

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      r_count  <= r_count + (PTR_W+1)'(w_push) - w_pop_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arm_if_align.sv
`default_nettype none
// ============================================================================
//  Module      : arm_if_align
//  Description : Fetch alignment stage. Buffers halfwords, classifies the head
//                as 16/32-bit Thumb and presents one whole, left-justified
//                instruction per cycle through a registered valid/stall port.
//  Revision    : 1.0  initial release
// ============================================================================
module arm_if_align
  import arm_core_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HW_W-1:0]   inst_hw,
  input  logic              hw_valid,
  output logic              hw_ready,
  input  logic              flush,
  input  logic              stall,
  output logic [INST_W-1:0] valid_inst,
  output logic              inst_valid,
  output logic              is_32bit
);

  logic [HW_W-1:0]   w_h0;
  logic [HW_W-1:0]   w_h1;
  logic [PTR_W:0]    w_count;
  logic              w_push;
  logic              w_head_32;
  logic              w_load;
  logic              w_emit16;
  logic              w_emit32;

  logic [INST_W-1:0] r_valid_inst;
  logic              r_inst_valid;
  logic              r_is_32bit;

  // Ready depends on the current count only; a same-cycle pop is not credited
  assign hw_ready  = (w_count < (PTR_W+1)'(DEPTH));
  assign w_push    = hw_valid && hw_ready && !flush;

  assign w_head_32 = is_thumb32(w_h0);
  assign w_load    = !r_inst_valid || !stall;
  // A 32-bit instruction is only released once both halves are buffered
  assign w_emit16  = w_load && !w_head_32 && (w_count != '0);
  assign w_emit32  = w_load &&  w_head_32 && (w_count >= (PTR_W+1)'(2));

  arm_hw_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_wr_data (inst_hw),
    .i_pop_one (w_emit16 && !flush),
    .i_pop_two (w_emit32 && !flush),
    .o_h0      (w_h0),
    .o_h1      (w_h1),
    .o_count   (w_count)
  );

  // Output pipeline register; data holds when nothing new is loaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_inst <= '0;
      r_inst_valid <= 1'b0;
      r_is_32bit   <= 1'b0;
    end else if (flush) begin
      r_inst_valid <= 1'b0;
    end else if (w_load) begin
      if (w_emit32) begin
        r_valid_inst <= {w_h0, w_h1};
        r_is_32bit   <= 1'b1;
        r_inst_valid <= 1'b1;
      end else if (w_emit16) begin
        r_valid_inst <= {w_h0, 16'h0000};
        r_is_32bit   <= 1'b0;
        r_inst_valid <= 1'b1;
      end else begin
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign valid_inst = r_valid_inst;
  assign inst_valid = r_inst_valid;
  assign is_32bit   = r_is_32bit;

endmodule
`default_nettype wire
